// File: rtl/l1_dist_seq_pkg.sv
// l1_dist_seq_pkg: shared definitions for the L1-distance sequencer.
//   NBIT_DEF   default unsigned operand width of x and w
//   ACC_W_DEF  default accumulator / result width
//   LEN_W_DEF  default pair-count field width
//   l1_state_e sequencer state encoding (L1_IDLE, L1_RUN, L1_DRAIN, L1_DONE)
package l1_dist_seq_pkg;
  localparam int NBIT_DEF  = 8;
  localparam int ACC_W_DEF = 18;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    L1_IDLE  = 2'd0,
    L1_RUN   = 2'd1,
    L1_DRAIN = 2'd2,
    L1_DONE  = 2'd3
  } l1_state_e;
endpackage

// File: rtl/l1_dist_seq_sub.sv
// l1_dist_seq_sub: ripple-carry subtractor, diff = a + ~b + 1 (mod 2^NBIT).
//   a    input  NBIT  minuend
//   b    input  NBIT  subtrahend
//   diff output NBIT  a - b
// Callers steer a >= b, so the carry out is always 1 and is not exported.
module l1_dist_seq_sub #(
  parameter int NBIT = 8
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  output logic [NBIT-1:0] diff
);
  logic [NBIT-1:0] c;
  logic [NBIT-1:0] nb;

  assign nb   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < NBIT; i++) begin : g_bit
    assign diff[i] = a[i] ^ nb[i] ^ c[i];
    if (i < NBIT - 1) begin : g_cy
      assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    end
  end
endmodule

// File: rtl/l1_dist_seq.sv
// l1_dist_seq: sequencer computing result = -sum|x_i - w_i| over i_len pairs
// with one shared subtractor.
//   i_clk    clock, rising edge
//   i_rstn   synchronous active-low reset
//   i_start  start job (sampled in IDLE), i_len pair count captured with it
//   i_valid / o_ready  pair handshake carrying i_x, i_w (unsigned)
//   o_busy   high in every state except IDLE
//   o_done   one-cycle pulse, o_result valid from this cycle and held
// Optional: define L1_DIST_SAT_EN to saturate the accumulator at
// 2^(ACC_W-1)-1 instead of wrapping mod 2^ACC_W.
module l1_dist_seq
  import l1_dist_seq_pkg::*;
#(
  parameter int NBIT  = NBIT_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [NBIT-1:0]  i_x,
  input  logic [NBIT-1:0]  i_w,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [ACC_W-1:0] o_result
);
  l1_state_e        state;
  logic [LEN_W-1:0] len_q, cnt;
  logic             p_valid;
  logic [NBIT-1:0]  p_x, p_w;
  logic [NBIT-1:0]  op_a, op_b, diff;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             hs;

  assign hs = (state == L1_RUN) && i_valid && o_ready;

  // Steer the larger operand to A so the subtractor yields |p_x - p_w|.
  assign op_a = (p_x >= p_w) ? p_x : p_w;
  assign op_b = (p_x >= p_w) ? p_w : p_x;

  l1_dist_seq_sub #(.NBIT(NBIT)) u_sub (
    .a    (op_a),
    .b    (op_b),
    .diff (diff)
  );

`ifdef L1_DIST_SAT_EN
  localparam logic [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
  logic [ACC_W:0] acc_sum;
  // acc never exceeds SAT_MAX, so one extra bit holds the raw sum.
  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(diff);
  assign acc_nxt = (acc_sum > SAT_MAX) ? SAT_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
`else
  assign acc_nxt = acc + ACC_W'(diff);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= L1_IDLE;
      len_q    <= '0;
      cnt      <= '0;
      p_valid  <= 1'b0;
      p_x      <= '0;
      p_w      <= '0;
      acc      <= '0;
      o_ready  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_done  <= 1'b0;
      p_valid <= hs;
      if (hs) begin
        p_x <= i_x;
        p_w <= i_w;
        cnt <= cnt + 1'b1;
      end
      if (p_valid) acc <= acc_nxt;

      case (state)
        L1_IDLE: if (i_start) begin
          len_q  <= i_len;
          cnt    <= '0;
          acc    <= '0;
          o_busy <= 1'b1;
          if (i_len == '0) begin
            state <= L1_DONE;
          end else begin
            state   <= L1_RUN;
            o_ready <= 1'b1;
          end
        end
        L1_RUN: if (hs && (cnt + 1'b1 == len_q)) begin
          state   <= L1_DRAIN;
          o_ready <= 1'b0;
        end
        // Last pipe entry lands in acc on this edge.
        L1_DRAIN: state <= L1_DONE;
        L1_DONE: begin
          state    <= L1_IDLE;
          o_busy   <= 1'b0;
          o_done   <= 1'b1;
          o_result <= '0 - acc;
        end
        default: state <= L1_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_dist_seq.sv
module tb_l1_dist_seq;
  localparam int NB = 8, AW = 18, LW = 8, AW2 = 10;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, valid = 1'b0;
  logic [LW-1:0] len = '0;
  logic [NB-1:0] x = '0, w = '0;
  logic          ready, busy, done, ready2, busy2, done2;
  logic [AW-1:0] result;
  logic [AW2-1:0] result2;

  always #5 clk = ~clk;

  l1_dist_seq #(.NBIT(NB), .ACC_W(AW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_len(len), .i_valid(valid),
    .i_x(x), .i_w(w), .o_ready(ready), .o_busy(busy), .o_done(done), .o_result(result));

  // Narrow-accumulator instance, same stimulus, exercises wrap / saturation.
  l1_dist_seq #(.NBIT(NB), .ACC_W(AW2), .LEN_W(LW)) dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_len(len), .i_valid(valid),
    .i_x(x), .i_w(w), .o_ready(ready2), .o_busy(busy2), .o_done(done2), .o_result(result2));

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Result of a job from its plain total of |x-w| for a given accumulator width.
  function automatic longint res_of(input longint sum, input int aw);
    longint m, eff;
    m = longint'(1) << aw;
`ifdef L1_DIST_SAT_EN
    eff = (sum > m/2 - 1) ? m/2 - 1 : sum;
`else
    eff = sum % m;
`endif
    return (m - eff) % m;
  endfunction

  // Behavioural model: job bookkeeping by counts and timing offsets.
  bit     m_busy = 0, m_ready = 0, m_done = 0;
  int     m_len = 0, m_cnt = 0, m_cd = 0;
  longint m_sum = 0, m_res = 0, m_res2 = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rstn) begin
      m_busy = 0; m_ready = 0; m_cd = 0; m_cnt = 0; m_sum = 0; m_res = 0; m_res2 = 0;
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_done = 1'b1; m_busy = 1'b0;
        m_res = res_of(m_sum, AW); m_res2 = res_of(m_sum, AW2);
      end
    end else if (m_ready) begin
      if (valid) begin
        m_sum += (x >= w) ? longint'(x) - longint'(w) : longint'(w) - longint'(x);
        m_cnt++;
        if (m_cnt == m_len) begin m_ready = 1'b0; m_cd = 2; end
      end
    end else if (!m_busy && start) begin
      m_len = int'(len); m_sum = 0; m_cnt = 0; m_busy = 1'b1;
      if (m_len == 0) m_cd = 1; else m_ready = 1'b1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("ready", ready, m_ready);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("result", result, m_res);
    chk("done2", done2, m_done);
    chk("result2", result2, m_res2);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1; len = LW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic send(input int xv, input int wv);
    bit ok = 1'b0;
    valid = 1'b1; x = NB'(xv); w = NB'(wv);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready) ok = 1'b1;
    end
    if (ok) step();
    else chk("handshake_timeout", 0, 1);
    valid = 1'b0;
  endtask

  // Count negedges until o_done; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    step();
  endtask

  int n;

  initial begin
    rstn = 1'b0;
    step(); chk_en = 1'b1;
    step();
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    rstn = 1'b1;
    step();

    // Basic sum: 7+7+255+0 = 269.
    do_start(4);
    send(10, 3); send(3, 10); send(0, 255); send(200, 200);
    wait_done(n);
    chk("basic_latency", n, 3);
    chk("basic_result", result, 262144 - 269);
    chk("model_basic", m_res, 262144 - 269);

    // Zero length.
    do_start(0);
    wait_done(n);
    chk("zero_latency", n, 2);
    chk("zero_result", result, 0);

    // Backpressure with random bubbles between pairs.
    do_start(4);
    send(10, 3);
    repeat ($urandom_range(1, 3)) step();
    send(3, 10);
    repeat ($urandom_range(1, 3)) step();
    send(0, 255);
    repeat ($urandom_range(1, 3)) step();
    send(200, 200);
    wait_done(n);
    chk("bp_latency", n, 3);
    chk("bp_result", result, 262144 - 269);

    // Reset mid-job after two accepted pairs.
    do_start(4);
    send(10, 3); send(3, 10);
    rstn = 1'b0;
    step();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rstn = 1'b1;
    step();
    do_start(1);
    send(5, 9);
    wait_done(n);
    chk("post_rst_result", result, 18'h3FFFC);

    // Start during RUN must be ignored.
    do_start(2);
    send(1, 0);
    start = 1'b1; len = 8'd7;
    step();
    start = 1'b0;
    send(0, 1);
    wait_done(n);
    chk("ign_latency", n, 3);
    chk("ign_result", result, 18'h3FFFE);
    chk("ign_idle", busy, 0);

    // Eight (255,0) pairs: 2040 total.
    do_start(8);
    for (int i = 0; i < 8; i++) send(255, 0);
    wait_done(n);
    chk("sat_wide_result", result, 262144 - 2040);
`ifdef L1_DIST_SAT_EN
    chk("sat_narrow_result", result2, 10'h201);
    chk("model_sat", m_res2, 513);
`else
    chk("wrap_narrow_result", result2, 10'd8);
    chk("model_wrap", m_res2, 8);
`endif

    step(); step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
